pe_link_arbiter: RTL and testbench
==================================

PE_LINK_ARBITER -- requirements
Module: pe_link_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 130: width of each tile-link data word.
REQ-002 SHALL have parameter BURST_MAX, default 4: maximum beats per grant; legal range 1..8.
REQ-003 SHALL have parameter CNT_BITS, default 3: burst counter width; 2^CNT_BITS >= BURST_MAX.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port ap_start  input  1  global enable; low freezes arbitration and input acceptance.
REQ-007 SHALL have ports in_data_n, in_data_s, in_data_e  input  DATA_WIDTH each  requester data; requester ids n=0, s=1, e=2.
REQ-008 SHALL have ports in_valid_n, in_valid_s, in_valid_e  input  1 each  requester word valid.
REQ-009 SHALL have ports in_last_n, in_last_s, in_last_e  input  1 each  final word of a requester packet.
REQ-010 SHALL have ports in_ready_n, in_ready_s, in_ready_e  output  1 each  word accepted when valid&ready.
REQ-011 SHALL have port out_data  output  DATA_WIDTH  registered shared-link data.
REQ-012 SHALL have port out_valid  output  1  out_data holds an undelivered word.
REQ-013 SHALL have port out_last  output  1  in_last of the word in out_data.
REQ-014 SHALL have port out_ready  input  1  downstream accepts when out_valid&out_ready.
REQ-015 SHALL have port grant_id  output  2  id of current/last granted requester.
REQ-016 SHALL have port busy  output  1  high when state is SERVE or out_valid is high.

Function
REQ-017 SHALL implement a two-state FSM, IDLE and SERVE, plus a 2-bit round-robin pointer rr_ptr (values 0..2).
REQ-018 In IDLE with ap_start=1 and any in_valid high, SHALL grant the first valid requester in order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3), load grant_id, clear burst_cnt, and enter SERVE next cycle.
REQ-019 No word SHALL be accepted in the IDLE cycle; arbitration latency is exactly one cycle.
REQ-020 In IDLE, in_ready_n/s/e SHALL all be 0.
REQ-021 In SERVE, only the granted in_ready SHALL be driven, equal to ap_start & (~out_valid | out_ready); non-granted in_ready SHALL be 0.
REQ-022 On an accepted word, out_data/out_last SHALL load the granted data/last and out_valid SHALL be 1 the next cycle; burst_cnt SHALL increment.
REQ-023 When out_valid&out_ready and no word is accepted in that cycle, out_valid SHALL clear next cycle.
REQ-024 While out_valid=1 and out_ready=0, out_data and out_last SHALL remain stable.
REQ-025 With out_ready held high and the granted requester continuously valid, SHALL sustain one word per cycle.
REQ-026 The grant SHALL release (SERVE->IDLE) on the cycle a word is accepted with in_last=1 or with burst_cnt=BURST_MAX-1; rr_ptr SHALL become (grant_id+1) mod 3.
REQ-027 If the granted requester drops valid mid-burst, SHALL stay in SERVE with grant held; no timeout.
REQ-028 With ap_start=0, SHALL neither grant nor accept; FSM, rr_ptr and burst_cnt hold; a pending out_valid word SHALL still drain on out_ready.
REQ-029 In IDLE, arbitration SHALL proceed regardless of out_valid; the first accept in SERVE obeys REQ-021.
REQ-030 grant_id SHALL hold its value in IDLE until the next grant.

Reset
REQ-031 reset low SHALL immediately force: state IDLE, rr_ptr=0, burst_cnt=0, grant_id=0, out_valid=0, out_last=0, out_data=0; busy=0.
REQ-032 Reset asserted mid-burst SHALL abandon the burst and the undelivered out_data word; after release the first grant starts from requester n.

Verification
REQ-033 After reset, all three valid, out_ready=1, ap_start=1, single-word packets (last=1) -> grants n,s,e,n in order; each word on out_data one cycle after its accept.
REQ-034 BURST_MAX=4, n sends 6-word packet with last on word 6, s valid -> n delivers 4 words, grant moves to s, n resumes after s finishes.
REQ-035 Granted e, out_ready low 3 cycles with out_valid=1 -> out_data stable, in_ready_e=0 those cycles, transfer resumes on out_ready=1.
REQ-036 ap_start dropped mid-burst with out_valid=1, out_ready=1 -> pending word drains, no new accepts, busy stays 1; ap_start high resumes same grant and burst_cnt.
REQ-037 reset pulsed low mid-burst at word 2 -> out_valid=0 asynchronously; after release, s and n both valid -> n granted first.

Source files
------------

// File: rtl/pe_link_arbiter.sv
// ============================================================================
// pe_link_arbiter : three-way round-robin burst arbiter onto one shared link
// Revision 1.0
// ============================================================================
`default_nettype none

module pe_link_arbiter #(
  parameter int DATA_WIDTH = 130,
  parameter int BURST_MAX  = 4,
  parameter int CNT_BITS   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ap_start,
  input  logic [DATA_WIDTH-1:0] in_data_n,
  input  logic [DATA_WIDTH-1:0] in_data_s,
  input  logic [DATA_WIDTH-1:0] in_data_e,
  input  logic                  in_valid_n,
  input  logic                  in_valid_s,
  input  logic                  in_valid_e,
  input  logic                  in_last_n,
  input  logic                  in_last_s,
  input  logic                  in_last_e,
  output logic                  in_ready_n,
  output logic                  in_ready_s,
  output logic                  in_ready_e,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [1:0]            grant_id,
  output logic                  busy
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SERVE = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_rr_ptr;
  logic [CNT_BITS-1:0]   r_burst_cnt;
  logic [1:0]            r_grant_id;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic                  r_out_last;

  logic [2:0]            w_vld_vec;
  logic [2:0]            w_sum;
  logic [1:0]            w_idx;
  logic [1:0]            w_pick;
  logic                  w_pick_vld;
  logic                  w_grant;
  logic [DATA_WIDTH-1:0] w_g_data;
  logic                  w_g_valid;
  logic                  w_g_last;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_release;

  assign w_vld_vec = {in_valid_e, in_valid_s, in_valid_n};

  // Scan from the farthest candidate back to rr_ptr so the nearest valid one wins.
  always_comb begin
    w_pick     = 2'd0;
    w_pick_vld = 1'b0;
    w_sum      = 3'd0;
    w_idx      = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + 3'(k);
      w_idx = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];
      if (w_vld_vec[w_idx]) begin
        w_pick     = w_idx;
        w_pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    case (r_grant_id)
      2'd1:    begin w_g_data = in_data_s; w_g_valid = in_valid_s; w_g_last = in_last_s; end
      2'd2:    begin w_g_data = in_data_e; w_g_valid = in_valid_e; w_g_last = in_last_e; end
      default: begin w_g_data = in_data_n; w_g_valid = in_valid_n; w_g_last = in_last_n; end
    endcase
  end

  assign w_ready   = (r_state == ST_SERVE) && ap_start && (!r_out_valid || out_ready);
  assign w_accept  = w_ready && w_g_valid;
  assign w_release = w_accept && (w_g_last || (r_burst_cnt == CNT_BITS'(BURST_MAX - 1)));
  assign w_grant   = (r_state == ST_IDLE) && ap_start && w_pick_vld;

  always_comb begin
    w_state_nxt = r_state;
    in_ready_n  = 1'b0;
    in_ready_s  = 1'b0;
    in_ready_e  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) w_state_nxt = ST_SERVE;
      end
      ST_SERVE: begin
        in_ready_n = w_ready && (r_grant_id == 2'd0);
        in_ready_s = w_ready && (r_grant_id == 2'd1);
        in_ready_e = w_ready && (r_grant_id == 2'd2);
        if (w_release) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr    <= 2'd0;
      r_burst_cnt <= '0;
      r_grant_id  <= 2'd0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_grant) begin
        r_grant_id  <= w_pick;
        r_burst_cnt <= '0;
      end else if (w_accept) begin
        r_burst_cnt <= r_burst_cnt + CNT_BITS'(1);
      end
      if (w_release) r_rr_ptr <= (r_grant_id == 2'd2) ? 2'd0 : r_grant_id + 2'd1;
      // Draining is deliberately independent of ap_start.
      if (w_accept) begin
        r_out_data  <= w_g_data;
        r_out_last  <= w_g_last;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign grant_id  = r_grant_id;
  assign busy      = (r_state == ST_SERVE) || r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_pe_link_arbiter.sv
// ============================================================================
// tb_pe_link_arbiter : directed bench with a transaction-level reference model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_pe_link_arbiter;
  localparam int DW = 130;
  localparam int BM = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ap_start = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data_n, in_data_s, in_data_e;
  logic          in_valid_n, in_valid_s, in_valid_e;
  logic          in_last_n, in_last_s, in_last_e;
  logic          in_ready_n, in_ready_s, in_ready_e;
  logic [DW-1:0] out_data;
  logic          out_valid, out_last, busy;
  logic [1:0]    grant_id;

  int tests = 0;
  int fails = 0;

  // Requester sources: words left, packet length, position in packet, sequence number.
  int src_words[3];
  int src_plen[3];
  int src_pos[3];
  int src_seq[3];
  bit hs[3];
  logic [DW-1:0] dq[$];

  // Reference model state
  bit            m_serv;
  int            m_own, m_ptr, m_beats;
  bit            m_ov, m_ol;
  logic [DW-1:0] m_od;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input int id, input int seq);
    logic [DW-1:0] p;
    p = '0;
    p[DW-1] = 1'b1;
    p[9:8]  = id[1:0];
    p[7:0]  = seq[7:0];
    return p;
  endfunction

  assign in_valid_n = src_words[0] > 0;
  assign in_valid_s = src_words[1] > 0;
  assign in_valid_e = src_words[2] > 0;
  assign in_last_n  = src_pos[0] == src_plen[0] - 1;
  assign in_last_s  = src_pos[1] == src_plen[1] - 1;
  assign in_last_e  = src_pos[2] == src_plen[2] - 1;
  assign in_data_n  = pat(0, src_seq[0]);
  assign in_data_s  = pat(1, src_seq[1]);
  assign in_data_e  = pat(2, src_seq[2]);

  pe_link_arbiter #(.DATA_WIDTH(DW), .BURST_MAX(BM), .CNT_BITS(3)) dut (
    .clk(clk), .reset(reset), .ap_start(ap_start),
    .in_data_n(in_data_n), .in_data_s(in_data_s), .in_data_e(in_data_e),
    .in_valid_n(in_valid_n), .in_valid_s(in_valid_s), .in_valid_e(in_valid_e),
    .in_last_n(in_last_n), .in_last_s(in_last_s), .in_last_e(in_last_e),
    .in_ready_n(in_ready_n), .in_ready_s(in_ready_s), .in_ready_e(in_ready_e),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .grant_id(grant_id), .busy(busy)
  );

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Sources advance just after the edge on which their handshake happened.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        if (hs[i]) begin
          src_seq[i]++;
          src_words[i]--;
          src_pos[i] = (src_pos[i] == src_plen[i] - 1) ? 0 : src_pos[i] + 1;
        end
      end
    end
  end

  // Compare process: check outputs against the model, then advance the model.
  always @(negedge clk) begin
    logic [2:0]    v, l, er;
    logic [DW-1:0] d[3];
    bit            take, found;
    int            id;
    v = {in_valid_e, in_valid_s, in_valid_n};
    l = {in_last_e, in_last_s, in_last_n};
    d[0] = in_data_n; d[1] = in_data_s; d[2] = in_data_e;
    hs[0] = in_valid_n && in_ready_n;
    hs[1] = in_valid_s && in_ready_s;
    hs[2] = in_valid_e && in_ready_e;
    if (!reset) begin
      hs[0] = 0; hs[1] = 0; hs[2] = 0;
      m_serv = 0; m_own = 0; m_ptr = 0; m_beats = 0;
      m_ov = 0; m_ol = 0; m_od = '0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", {in_ready_e, in_ready_s, in_ready_n}, 0);
    end else begin
      er = 3'b000;
      if (m_serv && ap_start && (!m_ov || out_ready)) er[m_own] = 1'b1;
      chk("in_ready_n", in_ready_n, er[0]);
      chk("in_ready_s", in_ready_s, er[1]);
      chk("in_ready_e", in_ready_e, er[2]);
      chk("out_valid", out_valid, m_ov);
      if (m_ov) begin
        chk("out_data", out_data, m_od);
        chk("out_last", out_last, m_ol);
      end
      chk("grant_id", grant_id, m_own[1:0]);
      chk("busy", busy, m_serv || m_ov);
      if (out_valid && out_ready) dq.push_back(out_data);

      take = m_serv && er[m_own] && v[m_own];
      if (!m_serv) begin
        found = 0;
        if (ap_start) begin
          for (int k = 0; k < 3; k++) begin
            id = (m_ptr + k) % 3;
            if (!found && v[id]) begin
              found = 1; m_own = id; m_serv = 1; m_beats = 0;
            end
          end
        end
      end else if (take) begin
        m_beats++;
        if (l[m_own] || m_beats == BM) begin
          m_serv = 0;
          m_ptr  = (m_own + 1) % 3;
        end
      end
      if (take) begin
        m_ov = 1; m_od = d[m_own]; m_ol = l[m_own];
      end else if (m_ov && out_ready) begin
        m_ov = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic src_set(input int i, input int words, input int plen);
    src_words[i] = words; src_plen[i] = plen; src_pos[i] = 0; src_seq[i] = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    ap_start = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) src_set(i, 0, 1);
    tick(2);
    dq.delete();
    reset = 1'b1;
  endtask

  task automatic wait_done(input string nm);
    int c;
    c = 0;
    while (c < 300 && (src_words[0] + src_words[1] + src_words[2] != 0 || busy)) begin
      tick(1);
      c++;
    end
    chk(nm, (c < 300), 1);
  endtask

  task automatic chk_seq(input string nm, input logic [DW-1:0] exp[$]);
    chk({nm, "_count"}, dq.size(), exp.size());
    for (int i = 0; i < exp.size() && i < dq.size(); i++)
      chk($sformatf("%s_w%0d", nm, i), dq[i], exp[i]);
  endtask

  initial begin
    logic [DW-1:0] hold;
    int c;
    for (int i = 0; i < 3; i++) begin src_set(i, 0, 1); hs[i] = 0; end
    tick(2);

    // Single-word packets, all requesters valid: n,s,e,n,s,e.
    do_reset();
    ap_start = 1'b1;
    for (int i = 0; i < 3; i++) src_set(i, 2, 1);
    wait_done("t1_done");
    chk_seq("t1", '{pat(0,0), pat(1,0), pat(2,0), pat(0,1), pat(1,1), pat(2,1)});

    // Burst cap: n's 6-word packet split 4 + 2 around s.
    do_reset();
    ap_start = 1'b1;
    src_set(0, 6, 6);
    src_set(1, 2, 2);
    wait_done("t2_done");
    chk_seq("t2", '{pat(0,0), pat(0,1), pat(0,2), pat(0,3), pat(1,0), pat(1,1), pat(0,4), pat(0,5)});

    // Back-pressure on e's burst.
    do_reset();
    ap_start = 1'b1;
    src_set(2, 4, 4);
    c = 0;
    while (c < 50 && !(out_valid && grant_id == 2'd2)) begin tick(1); c++; end
    chk("t3_reach", (c < 50), 1);
    out_ready = 1'b0;
    hold = out_data;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_stable", out_data, hold);
      chk("t3_ready_e_low", in_ready_e, 0);
      chk("t3_valid_held", out_valid, 1);
      tick(1);
    end
    out_ready = 1'b1;
    wait_done("t3_done");
    chk_seq("t3", '{pat(2,0), pat(2,1), pat(2,2), pat(2,3)});

    // ap_start pause mid-burst: drain continues, burst count is retained.
    do_reset();
    ap_start = 1'b1;
    src_set(0, 6, 6);
    src_set(1, 1, 1);
    c = 0;
    while (c < 50 && !out_valid) begin tick(1); c++; end
    chk("t4_reach", (c < 50), 1);
    tick(1);
    ap_start = 1'b0;
    #1;
    chk("t4_ready_n_low", in_ready_n, 0);
    chk("t4_busy", busy, 1);
    for (int i = 0; i < 2; i++) begin
      tick(1);
      chk("t4_drained", out_valid, 0);
      chk("t4_busy_hold", busy, 1);
      chk("t4_grant_hold", grant_id, 0);
    end
    ap_start = 1'b1;
    wait_done("t4_done");
    chk_seq("t4", '{pat(0,0), pat(0,1), pat(0,2), pat(0,3), pat(1,0), pat(0,4), pat(0,5)});

    // Asynchronous reset mid-burst, then fresh arbitration from n.
    do_reset();
    ap_start = 1'b1;
    src_set(0, 4, 4);
    src_set(1, 2, 2);
    c = 0;
    while (c < 50 && !(out_valid && out_data == pat(0,1))) begin tick(1); c++; end
    chk("t5_reach", (c < 50), 1);
    #1;
    reset = 1'b0;
    #1;
    chk("t5_async_valid", out_valid, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_data", out_data, 0);
    src_set(0, 1, 1);
    src_set(1, 1, 1);
    src_set(2, 0, 1);
    tick(2);
    dq.delete();
    reset = 1'b1;
    wait_done("t5_done");
    chk_seq("t5", '{pat(0,0), pat(1,0)});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
